id_ex_pipe_reg: RTL



---
 rtl/id_ex_pipe_reg_pkg.sv | 33 +++
 rtl/id_ex_pipe_reg_skid_buf.sv | 89 ++++++++
 rtl/id_ex_pipe_reg.sv | 92 +++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// rtl/id_ex_pipe_reg_pkg.sv - shared pipeline constants and types for inter-stage registers
//
// Purpose: control-bit positions, default widths, the stage payload layout and
//          the skid-buffer state encoding shared by the pipeline registers.
// Ports:   none (package).
package id_ex_pipe_reg_pkg;

  // Control-word bit positions; bits above CTRL_WMEM_BIT pass through untouched.
  localparam int CTRL_WREG_BIT = 0;
  localparam int CTRL_WMEM_BIT = 1;

  // Default widths used by the pipeline registers.
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_NUM_SRC    = 2;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CTRL_W     = 2;

  // Stage payload layout {ctrl, src, wreg}. Parametrised stages declare a local
  // struct with the same field order so the packed image is identical.
  typedef struct packed {
    logic [DEF_CTRL_W-1:0]             ctrl;
    logic [DEF_NUM_SRC*DEF_DATA_W-1:0] src;
    logic [DEF_REG_ADDR_W-1:0]         wreg;
  } stage_payload_t;

  // Skid-buffer occupancy encoded as {main_v, skid_v}; 2'b01 is illegal.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/id_ex_pipe_reg_skid_buf.sv
// rtl/id_ex_pipe_reg_skid_buf.sv - generic 2-entry skid buffer with flush
//
// Purpose: decouples producer ready from consumer ready. in_ready depends only
//          on the registered occupancy, so the producer never sees a
//          combinational path from out_ready.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               drop held entries and any entry accepted this cycle
//   in_valid/in_ready   producer handshake, in_data payload
//   out_valid/out_ready consumer handshake, out_data payload (main entry)
module pipe_skid_buf
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc;
  logic         take;

  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];
  assign out_data  = main_q;

  assign acc  = in_valid & in_ready;
  assign take = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data is left stale; only occupancy matters after a flush.
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (acc) begin
            state_d = SKID_ONE;
            main_d  = in_data;
          end
        end
        SKID_ONE: begin
          if (acc && take) begin
            main_d = in_data;
          end else if (acc) begin
            // Consumer stalled after we advertised ready: park the beat.
            state_d = SKID_FULL;
            skid_d  = in_data;
          end else if (take) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (take) begin
            state_d = SKID_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID to EX pipeline register with skid buffer, flush and bubble counter
//
// Purpose: carries {ctrl, src, wreg} from decode to execute through a 2-entry
//          skid buffer, gates ctrl to zero on empty slots and counts bubbles.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               discard held and incoming entries this cycle
//   id_valid/id_ready   decode-side handshake (id_ready registered)
//   id_ctrl/src/wreg    incoming payload
//   ex_valid/ex_ready   execute-side handshake
//   ex_ctrl/src/wreg    outgoing payload, ex_ctrl zero while ex_valid=0
//   bubble_cnt          saturating count of cycles with ex_valid=0
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [CTRL_W-1:0]         id_ctrl,
  input  logic [NUM_SRC*DATA_W-1:0] id_src,
  input  logic [REG_ADDR_W-1:0]     id_wreg,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [CTRL_W-1:0]         ex_ctrl,
  output logic [NUM_SRC*DATA_W-1:0] ex_src,
  output logic [REG_ADDR_W-1:0]     ex_wreg,
  output logic [CNT_W-1:0]          bubble_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0]         ctrl;
    logic [NUM_SRC*DATA_W-1:0] src;
    logic [REG_ADDR_W-1:0]     wreg;
  } payload_t;

  localparam int               PAYLOAD_W = $bits(payload_t);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  payload_t         in_pl;
  payload_t         out_pl;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  assign in_pl.ctrl = id_ctrl;
  assign in_pl.src  = id_src;
  assign in_pl.wreg = id_wreg;

  pipe_skid_buf #(
    .W(PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (id_valid),
    .in_ready (id_ready),
    .in_data  (in_pl),
    .out_valid(ex_valid),
    .out_ready(ex_ready),
    .out_data (out_pl)
  );

  // Stale data may sit in the main entry after a flush, so ctrl is gated to
  // keep write enables from firing on a bubble.
  assign ex_ctrl = ex_valid ? out_pl.ctrl : '0;
  assign ex_src  = out_pl.src;
  assign ex_wreg = out_pl.wreg;

  always_comb begin
    bubble_d = bubble_q;
    if (!ex_valid && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;

endmodule
